// File: rtl/fan_pwm_tach_pkg.sv
// Purpose: default sizing constants and shared types for the fan PWM/tach controller.
// Latency: none (types and constants only).
// Backpressure: none.
package fan_pwm_tach_pkg;

  localparam int DefNumChannels  = 4;
  localparam int DefCntWidth     = 8;
  localparam int DefPrescWidth   = 16;
  localparam int DefTachWinWidth = 24;
  localparam int DefTachCntWidth = 16;
  localparam int DefSyncStages   = 2;

  typedef logic [DefCntWidth-1:0]     duty_t;
  typedef logic [DefTachCntWidth-1:0] tach_cnt_t;

  // Shared timing configuration at default widths: tick divider, PWM period, tach window
  typedef struct packed {
    logic [DefPrescWidth-1:0]   presc;
    duty_t                      period;
    logic [DefTachWinWidth-1:0] win;
  } cfg_t;

endpackage

// File: rtl/fan_pwm_tach_ctrl_if.sv
// Purpose: control/status bundle between the SoC side (master) and the fan controller (slave).
// Latency: none (wires only).
// Backpressure: none; all fields are level or single-cycle strobes.
interface fan_pwm_tach_ctrl_if
  import fan_pwm_tach_pkg::*;
#(
  parameter int NumChannels  = DefNumChannels,
  parameter int CntWidth     = DefCntWidth,
  parameter int PrescWidth   = DefPrescWidth,
  parameter int TachWinWidth = DefTachWinWidth,
  parameter int TachCntWidth = DefTachCntWidth
) ();

  logic [NumChannels-1:0]              en_i;
  logic [PrescWidth-1:0]               presc_i;
  logic [CntWidth-1:0]                 period_i;
  logic [NumChannels*CntWidth-1:0]     duty_i;
  logic [NumChannels-1:0]              duty_valid_i;
  logic [NumChannels-1:0]              pwm_o;
  logic [NumChannels-1:0]              tach_i;
  logic [TachWinWidth-1:0]             tach_win_i;
  logic [NumChannels*TachCntWidth-1:0] tach_cnt_o;
  logic                                tach_valid_o;
  logic [NumChannels-1:0]              stall_o;

  modport master (
    output en_i, presc_i, period_i, duty_i, duty_valid_i, tach_i, tach_win_i,
    input  pwm_o, tach_cnt_o, tach_valid_o, stall_o
  );

  modport slave (
    input  en_i, presc_i, period_i, duty_i, duty_valid_i, tach_i, tach_win_i,
    output pwm_o, tach_cnt_o, tach_valid_o, stall_o
  );

endinterface

// File: rtl/fan_pwm_tach_chan.sv
// Purpose: one fan channel: shadowed duty, PWM compare, tach edge counter and stall flag.
// Latency: pwm 1 cycle after cnt; a tach edge is counted SyncStages+1 cycles after it arrives.
// Backpressure: none; duty strobes always accepted, last strobe before a wrap wins.
module fan_pwm_tach_chan
  import fan_pwm_tach_pkg::*;
#(
  parameter int CntWidth     = DefCntWidth,
  parameter int TachCntWidth = DefTachCntWidth,
  parameter int SyncStages   = DefSyncStages
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en,
  input  logic [CntWidth-1:0]     duty,
  input  logic                    duty_valid,
  input  logic                    wrap,
  input  logic [CntWidth-1:0]     cnt,
  input  logic                    win_end,
  input  logic                    tach,
  output logic                    pwm,
  output logic [TachCntWidth-1:0] tach_cnt,
  output logic                    stall
);

  localparam logic [TachCntWidth-1:0] EdgeMax = '1;

  logic [CntWidth-1:0]     pending_q;
  logic [CntWidth-1:0]     active_q;
  logic                    tach_sync;
  logic                    tach_sync_d;
  logic                    tach_rise;
  logic [TachCntWidth-1:0] edge_q;
  logic [TachCntWidth-1:0] edge_total;

  // Pending takes each strobe; active only follows it at a period wrap or while disabled,
  // so a period in flight is never cut short and a re-enable starts with the latest duty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      if (duty_valid) begin
        pending_q <= duty;
      end
      if (wrap || !en) begin
        active_q <= pending_q;
      end
    end
  end

  // Registered compare keeps the output glitch-free; duty above the period gives constant high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en & (cnt < active_q);
    end
  end

  sync_cell #(
    .Stages(SyncStages)
  ) u_tach_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (tach),
    .q     (tach_sync)
  );

  // Delayed copy of the synchronised tach level for rising-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tach_sync_d <= 1'b0;
    end else begin
      tach_sync_d <= tach_sync;
    end
  end

  assign tach_rise  = tach_sync & ~tach_sync_d;
  // Count including this cycle's edge, saturating at all-ones
  assign edge_total = (tach_rise && (edge_q != EdgeMax)) ? edge_q + TachCntWidth'(1) : edge_q;

  // At window end publish the count, restart counting and re-evaluate the stall flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q   <= '0;
      tach_cnt <= '0;
      stall    <= 1'b0;
    end else if (win_end) begin
      edge_q   <= '0;
      tach_cnt <= edge_total;
      stall    <= en & (edge_total == '0);
    end else begin
      edge_q   <= edge_total;
    end
  end

endmodule

// File: rtl/sync_cell.sv
// Purpose: multi-flop synchroniser for a single asynchronous level input.
// Latency: Stages clk_i cycles from d to q.
// Backpressure: none.
module sync_cell #(
  parameter int Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] ff_q;

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[Stages-2:0], d};
    end
  end

  assign q = ff_q[Stages-1];

endmodule

// File: rtl/fan_pwm_tach_ctrl.sv
// Purpose: multi-channel fan controller; shared prescaler, PWM period and tach window counters.
// Latency: pwm_o 1 cycle after the period counter; tach_cnt_o/tach_valid_o 1 cycle after window end.
// Backpressure: none; tach_valid_o is a single-cycle pulse with no acknowledge.
module fan_pwm_tach_ctrl
  import fan_pwm_tach_pkg::*;
#(
  parameter int NumChannels  = DefNumChannels,
  parameter int CntWidth     = DefCntWidth,
  parameter int PrescWidth   = DefPrescWidth,
  parameter int TachWinWidth = DefTachWinWidth,
  parameter int TachCntWidth = DefTachCntWidth,
  parameter int SyncStages   = DefSyncStages
) (
  input logic                clk_i,
  input logic                rst_ni,
  fan_pwm_tach_ctrl_if.slave bus
);

  logic [PrescWidth-1:0]               presc_q;
  logic [CntWidth-1:0]                 cnt_q;
  logic [TachWinWidth-1:0]             win_q;
  logic                                tick;
  logic                                wrap;
  logic                                win_end;
  logic                                tach_valid_q;
  logic [NumChannels-1:0]              pwm_v;
  logic [NumChannels-1:0]              stall_v;
  logic [TachCntWidth-1:0]             tach_cnt_a [NumChannels];
  logic [NumChannels*TachCntWidth-1:0] tach_cnt_flat;

  // >= compares let a lowered limit take effect by wrapping on the next cycle
  assign tick    = presc_q >= bus.presc_i;
  assign wrap    = tick && (cnt_q >= bus.period_i);
  assign win_end = win_q >= bus.tach_win_i;

  // Prescaler: one tick every presc_i+1 cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PrescWidth'(1);
    end
  end

  // Period counter shared by all channels, advanced on ticks only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= wrap ? '0 : cnt_q + CntWidth'(1);
    end
  end

  // Tach window counter in raw clock cycles, plus the result-valid pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q        <= '0;
      tach_valid_q <= 1'b0;
    end else begin
      win_q        <= win_end ? '0 : win_q + TachWinWidth'(1);
      tach_valid_q <= win_end;
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    fan_pwm_tach_chan #(
      .CntWidth    (CntWidth),
      .TachCntWidth(TachCntWidth),
      .SyncStages  (SyncStages)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en        (bus.en_i[c]),
      .duty      (bus.duty_i[c*CntWidth +: CntWidth]),
      .duty_valid(bus.duty_valid_i[c]),
      .wrap      (wrap),
      .cnt       (cnt_q),
      .win_end   (win_end),
      .tach      (bus.tach_i[c]),
      .pwm       (pwm_v[c]),
      .tach_cnt  (tach_cnt_a[c]),
      .stall     (stall_v[c])
    );
  end

  // Flatten per-channel counts onto the output bus
  always_comb begin
    tach_cnt_flat = '0;
    for (int c = 0; c < NumChannels; c++) begin
      tach_cnt_flat[c*TachCntWidth +: TachCntWidth] = tach_cnt_a[c];
    end
  end

  assign bus.pwm_o        = pwm_v;
  assign bus.stall_o      = stall_v;
  assign bus.tach_cnt_o   = tach_cnt_flat;
  assign bus.tach_valid_o = tach_valid_q;

endmodule
